serial_subtractor: RTL and testbench



---
 rtl/sub_pkg.sv | 16 +
 rtl/sub_chunk.sv | 24 ++
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding and
// the slice-counter width function.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // A single-slice configuration still needs a one-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK_W-bit ripple-borrow subtractor built from full-subtractor
// cells: diff = a - b - borrow_in, borrow_out from the top cell.
module sub_chunk #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               borrow_in,
  output logic [CHUNK_W-1:0] diff,
  output logic               borrow_out
);

  logic [CHUNK_W:0] chain;

  assign chain[0] = borrow_in;

  for (genvar i = 0; i < CHUNK_W; i++) begin : g_cell
    assign diff[i]      = a[i] ^ b[i] ^ chain[i];
    assign chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign borrow_out = chain[CHUNK_W];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, one CHUNK_W slice per clock,
// LSB first. Define SUB_OVF_EN to enable the signed-overflow flag on ovf_o.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  sub_state_e state, state_nxt;

  logic [WIDTH-1:0]   a_q, b_q, diff_q;
  logic               brw_q;
  logic [CW-1:0]      k_q;

  logic [CHUNK_W-1:0] a_sl, b_sl, d_sl;
  logic               brw_sl;
  int                 lo;

  always_comb begin
    lo   = int'(k_q) * CHUNK_W;
    a_sl = a_q[lo +: CHUNK_W];
    b_sl = b_q[lo +: CHUNK_W];
  end

  // Single shared slice subtractor, steered by the slice counter.
  sub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a          (a_sl),
    .b          (b_sl),
    .borrow_in  (brw_q),
    .diff       (d_sl),
    .borrow_out (brw_sl)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_nxt = RUN;
      end
      RUN:     if (k_q == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      k_q      <= '0;
      valid_o  <= 1'b0;
      diff_o   <= '0;
      borrow_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          a_q   <= a_i;
          b_q   <= b_i;
          brw_q <= borrow_i;
          k_q   <= '0;
        end
        RUN: begin
          diff_q[lo +: CHUNK_W] <= d_sl;
          brw_q                 <= brw_sl;
          k_q                   <= k_q + 1'b1;
        end
        DONE: begin
          diff_o   <= diff_q;
          borrow_o <= brw_q;
          valid_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVF_EN
  // Operands of opposite sign whose result sign differs from the minuend.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      ovf_o <= 1'b0;
    else if (state == DONE)
      ovf_o <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
  end
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=16, CHUNK_W=4 with a
// plain-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int N   = W / C;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, valid, bout, ovf;
  logic [W-1:0] diff;

  int total  = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(W), .CHUNK_W(C)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .borrow_i (bin),
    .ready_o  (ready),
    .valid_o  (valid),
    .diff_o   (diff),
    .borrow_o (bout),
    .ovf_o    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Returns {ovf, borrow, diff} from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int           r;
    logic [W-1:0] d;
    logic         br, o;
    r  = int'(x) - int'(y) - int'(bi);
    d  = r[W-1:0];
    br = (r < 0);
`ifdef SUB_OVF_EN
    o  = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
`else
    o  = 1'b0;
`endif
    return {o, br, d};
  endfunction

  // Leaves the caller at the first negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    a = x; b = y; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_busy", ready, 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic bi);
    int           n;
    logic [W+1:0] e;
    e = model(x, y, bi);
    issue(x, y, bi);
    wait_valid(n);
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_diff"}, diff, e[W-1:0]);
    chk({tag, "_borrow"}, bout, e[W]);
    chk({tag, "_ovf"}, ovf, e[W+1]);
    @(negedge clk);
    chk({tag, "_pulse"}, valid, 0);
    chk({tag, "_hold"}, diff, e[W-1:0]);
  endtask

  initial begin
    int           n, cnt;
    logic [W+1:0] e1, e2;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", bout, 0);
    chk("rst_ovf", ovf, 0);

    // Directed cases
    op("basic", 16'h1234, 16'h0034, 1'b0);
    op("brw_b1", 16'h0000, 16'h0001, 1'b0);
    op("brw_in", 16'h0000, 16'h0000, 1'b1);
    op("ovf", 16'h8000, 16'h0001, 1'b0);
    op("ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0);
    op("eq", 16'hABCD, 16'hABCD, 1'b0);

    // Randomized
    for (int i = 0; i < 16; i++)
      op("rand", W'($urandom), W'($urandom), 1'($urandom));

    // start_i held high through RUN with different operands
    e1 = model(16'h5555, 16'h1111, 1'b0);
    e2 = model(16'h0F00, 16'h0F01, 1'b1);
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0F00; b = 16'h0F01; bin = 1'b1;
    wait_valid(n);
    chk("held_lat1", n, LAT);
    chk("held_diff1", diff, e1[W-1:0]);
    chk("held_borrow1", bout, e1[W]);
    chk("held_ready", ready, 1);
    @(negedge clk);
    start = 1'b0;
    chk("held_accept", ready, 0);
    wait_valid(n);
    chk("held_lat2", n, LAT);
    chk("held_diff2", diff, e2[W-1:0]);
    chk("held_borrow2", bout, e2[W]);
    @(negedge clk);

    // Reset in the 2nd RUN cycle
    issue(16'h4321, 16'h1234, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", bout, 0);
    chk("abort_valid", valid, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    chk("abort_no_valid", cnt, 0);

    // Normal operation after abort
    op("post_abort", 16'h0100, 16'h0001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
